// File: rtl/leaf_bft_endpoint_pkg.sv
`default_nettype none
// ============================================================================
// Module   : leaf_bft_endpoint_pkg
// Brief    : Shared constants, packet field layout and control-state type
//            for the BFT leaf endpoint.
// Revision : 1.0 - initial release
// ============================================================================
package leaf_bft_endpoint_pkg;

    localparam int c_PKT_W    = 49;
    localparam int c_DATA_W   = 32;
    localparam int c_ADDR_W   = 5;
    localparam int c_PORT_W   = 4;
    localparam int c_SEQ_W    = 7;
    localparam int c_TX_DEPTH = 16;
    localparam int c_RX_DEPTH = 16;

    // Packet layout, MSB first: valid | addr | port | seq | data
    localparam int c_DATA_LSB  = 0;
    localparam int c_SEQ_LSB   = c_DATA_LSB + c_DATA_W;
    localparam int c_PORT_LSB  = c_SEQ_LSB + c_SEQ_W;
    localparam int c_ADDR_LSB  = c_PORT_LSB + c_PORT_W;
    localparam int c_VALID_BIT = c_ADDR_LSB + c_ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/leaf_bft_endpoint_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock first-word-fall-through FIFO; the head entry is
//            visible on o_rdata whenever o_empty is low.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_rd,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;

    // Callers only assert i_wr/i_rd when legal, so no guarding is done here.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_wr) r_mem[r_wr_ptr[c_AW-1:0]] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr[c_AW-1:0]];
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);

endmodule
`default_nettype wire

// File: rtl/leaf_bft_endpoint.sv
`default_nettype none
// ============================================================================
// Module   : leaf_bft_endpoint
// Brief    : BFT leaf endpoint: packs upstream words into sequenced packets
//            toward the leaf and buffers incoming leaf packets downstream.
// Revision : 1.0 - initial release
// ============================================================================
module leaf_bft_endpoint
    import leaf_bft_endpoint_pkg::*;
#(
    parameter int PKT_W    = c_PKT_W,
    parameter int DATA_W   = c_DATA_W,
    parameter int ADDR_W   = c_ADDR_W,
    parameter int PORT_W   = c_PORT_W,
    parameter int SEQ_W    = c_SEQ_W,
    parameter int TX_DEPTH = c_TX_DEPTH,
    parameter int RX_DEPTH = c_RX_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_req,
    input  logic              stop_req,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [ADDR_W-1:0] tx_addr,
    input  logic [PORT_W-1:0] tx_port,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [PKT_W-1:0]  din_leaf_bft2interface,
    input  logic [PKT_W-1:0]  dout_leaf_interface2bft,
    output logic              resend,
    output logic              ap_start,
    output logic [DATA_W-1:0] rx_data,
    output logic [ADDR_W-1:0] rx_addr,
    output logic [PORT_W-1:0] rx_port,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic [15:0]       drop_cnt
);

    localparam int c_ENT_W = ADDR_W + PORT_W + DATA_W;

    state_t             r_state;
    logic               r_ap_start;
    logic [PKT_W-1:0]   r_dout;
    logic [SEQ_W-1:0]   r_tx_seq;
    logic               r_resend;
    logic [15:0]        r_drop_cnt;

    logic               w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
    logic [c_ENT_W-1:0] w_tx_head;
    logic               w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
    logic [c_ENT_W-1:0] w_rx_wdata, w_rx_head;
    logic               w_active, w_in_valid, w_drop;
    logic               w_unused_seq;

    assign w_active   = (r_state != ST_IDLE);
    assign tx_ready   = !w_tx_full && (r_state == ST_RUN);
    assign w_tx_push  = tx_valid && tx_ready;
    assign w_tx_pop   = w_active && !w_tx_empty;

    assign w_in_valid = dout_leaf_interface2bft[c_VALID_BIT];
    assign rx_valid   = !w_rx_empty;
    assign w_rx_pop   = rx_valid && rx_ready;
    // A full RX FIFO still accepts when its head leaves in the same cycle.
    assign w_rx_push  = w_in_valid && (!w_rx_full || w_rx_pop);
    assign w_drop     = w_in_valid && !w_rx_push;
    assign w_rx_wdata = {dout_leaf_interface2bft[c_ADDR_LSB +: ADDR_W],
                         dout_leaf_interface2bft[c_PORT_LSB +: PORT_W],
                         dout_leaf_interface2bft[c_DATA_LSB +: DATA_W]};
    assign w_unused_seq = ^dout_leaf_interface2bft[c_SEQ_LSB +: SEQ_W];

    sync_fifo #(.WIDTH(c_ENT_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_wr    (w_tx_push),
        .i_wdata ({tx_addr, tx_port, tx_data}),
        .i_rd    (w_tx_pop),
        .o_rdata (w_tx_head),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty)
    );

    sync_fifo #(.WIDTH(c_ENT_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_wr    (w_rx_push),
        .i_wdata (w_rx_wdata),
        .i_rd    (w_rx_pop),
        .o_rdata (w_rx_head),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_ap_start <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (start_req) begin
                    r_state    <= ST_RUN;
                    r_ap_start <= 1'b1;
                end
                ST_RUN: if (stop_req) r_state <= ST_DRAIN;
                ST_DRAIN: begin
                    if (start_req) begin
                        r_state <= ST_RUN;
                    end else if (w_tx_empty && !r_dout[c_VALID_BIT]) begin
                        r_state    <= ST_IDLE;
                        r_ap_start <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_ap_start <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dout   <= '0;
            r_tx_seq <= '0;
        end else if (w_tx_pop) begin
            r_dout   <= {1'b1, w_tx_head[c_ENT_W-1:DATA_W], r_tx_seq,
                         w_tx_head[DATA_W-1:0]};
            r_tx_seq <= r_tx_seq + 1'b1;
        end else begin
            r_dout   <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_resend   <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_resend <= w_drop;
            if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign din_leaf_bft2interface = r_dout;
    assign ap_start = r_ap_start;
    assign resend   = r_resend;
    assign drop_cnt = r_drop_cnt;
    assign rx_addr  = w_rx_head[c_ENT_W-1 -: ADDR_W];
    assign rx_port  = w_rx_head[DATA_W +: PORT_W];
    assign rx_data  = w_rx_head[DATA_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_leaf_bft_endpoint.sv
`default_nettype none
// ============================================================================
// Module   : tb_leaf_bft_endpoint
// Brief    : Self-checking bench for leaf_bft_endpoint against a queue-based
//            behavioural model, plus directed scenario checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_leaf_bft_endpoint;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1, start_req = 1'b0, stop_req = 1'b0;
    logic        tx_valid = 1'b0, rx_ready = 1'b0;
    logic [31:0] tx_data = '0;
    logic [4:0]  tx_addr = '0;
    logic [3:0]  tx_port = '0;
    logic [48:0] dout_in = '0;
    logic        tx_ready, resend, ap_start, rx_valid;
    logic [48:0] din;
    logic [31:0] rx_data;
    logic [4:0]  rx_addr;
    logic [3:0]  rx_port;
    logic [15:0] drop_cnt;

    leaf_bft_endpoint dut (
        .clk(clk), .reset(reset), .start_req(start_req), .stop_req(stop_req),
        .tx_data(tx_data), .tx_addr(tx_addr), .tx_port(tx_port),
        .tx_valid(tx_valid), .tx_ready(tx_ready),
        .din_leaf_bft2interface(din), .dout_leaf_interface2bft(dout_in),
        .resend(resend), .ap_start(ap_start),
        .rx_data(rx_data), .rx_addr(rx_addr), .rx_port(rx_port),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .drop_cnt(drop_cnt)
    );

    int n_vec = 0, n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // State: 0 idle, 1 running, 2 draining. Queue entries are {addr,port,data}.
    logic [40:0] m_txq[$];
    logic [40:0] m_rxq[$];
    int          m_state = 0;
    logic [48:0] m_out = '0;
    logic        m_resend = 1'b0;
    logic [15:0] m_drop = '0;
    logic [6:0]  m_seq = '0;
    logic        m_ap = 1'b0;

    always @(posedge clk) begin
        int          tx_n, rx_n;
        bit          acc, pop;
        logic [48:0] prev_out;
        logic [40:0] head;
        if (reset) begin
            m_txq.delete(); m_rxq.delete();
            m_state = 0; m_out = '0; m_resend = 1'b0; m_drop = '0; m_seq = '0; m_ap = 1'b0;
        end else begin
            tx_n = m_txq.size();
            rx_n = m_rxq.size();
            acc  = tx_valid && (m_state == 1) && (tx_n < 16);
            pop  = (rx_n > 0) && rx_ready;
            prev_out = m_out;
            if (m_state != 0 && tx_n > 0) begin
                head  = m_txq.pop_front();
                m_out = {1'b1, head[40:36], head[35:32], m_seq, head[31:0]};
                m_seq = m_seq + 7'd1;
            end else begin
                m_out = '0;
            end
            if (acc) m_txq.push_back({tx_addr, tx_port, tx_data});
            if (pop) void'(m_rxq.pop_front());
            m_resend = 1'b0;
            if (dout_in[48]) begin
                if (rx_n < 16 || pop) m_rxq.push_back({dout_in[47:39], dout_in[31:0]});
                else begin
                    m_resend = 1'b1;
                    if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
                end
            end
            case (m_state)
                0: if (start_req) m_state = 1;
                1: if (stop_req) m_state = 2;
                default: if (start_req) m_state = 1;
                         else if (tx_n == 0 && !prev_out[48]) m_state = 0;
            endcase
            m_ap = (m_state != 0);
        end
    end

    bit chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("din", {15'd0, din}, {15'd0, m_out});
            check("resend", {63'd0, resend}, {63'd0, m_resend});
            check("ap_start", {63'd0, ap_start}, {63'd0, m_ap});
            check("tx_ready", {63'd0, tx_ready}, {63'd0, (m_state == 1 && m_txq.size() < 16)});
            check("rx_valid", {63'd0, rx_valid}, {63'd0, (m_rxq.size() > 0)});
            check("drop_cnt", {48'd0, drop_cnt}, {48'd0, m_drop});
            if (m_rxq.size() > 0)
                check("rx_head", {23'd0, rx_addr, rx_port, rx_data}, {23'd0, m_rxq[0]});
        end
    end

    // ---------------- monitors for directed scenarios ----------------
    bit         log_en = 1'b0, rs_en = 1'b0, em_en = 1'b0;
    logic [6:0] seq_log[$];
    int         rs_cnt = 0, em_cnt = 0;
    always @(negedge clk) begin
        if (log_en && din[48]) seq_log.push_back(din[38:32]);
        if (rs_en && resend) rs_cnt++;
        if (em_en && din[48]) em_cnt++;
    end

    task automatic push_word(input logic [31:0] d, input logic [4:0] a, input logic [3:0] p);
        tx_valid = 1'b1; tx_data = d; tx_addr = a; tx_port = p;
    endtask

    task automatic rand_pkt(input bit force_valid);
        logic [63:0] t;
        t = {$urandom, $urandom};
        dout_in = t[48:0];
        if (force_valid) dout_in[48] = 1'b1;
    endtask

    initial begin
        logic [48:0] exp_pkt;
        int          waited, vcnt;

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;
        check("rst_din", {15'd0, din}, 64'd0);
        check("rst_resend", {63'd0, resend}, 64'd0);
        check("rst_ap_start", {63'd0, ap_start}, 64'd0);
        check("rst_tx_ready", {63'd0, tx_ready}, 64'd0);
        check("rst_rx_valid", {63'd0, rx_valid}, 64'd0);

        // start
        start_req = 1'b1;
        @(negedge clk);
        start_req = 1'b0;
        check("start_ap", {63'd0, ap_start}, 64'd1);
        check("start_ready", {63'd0, tx_ready}, 64'd1);

        // first packet
        push_word(32'hDEADBEEF, 5'd3, 4'd2);
        @(negedge clk);
        tx_valid = 1'b0;
        @(negedge clk);
        exp_pkt = {1'b1, 5'd3, 4'd2, 7'd0, 32'hDEADBEEF};
        check("first_pkt", {15'd0, din}, {15'd0, exp_pkt});

        // sequence wrap over 130 packets
        @(negedge clk);
        log_en = 1'b1;
        for (int i = 0; i < 130; i++) begin
            push_word($urandom, 5'($urandom), 4'($urandom));
            @(negedge clk);
        end
        tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        log_en = 1'b0;
        check("seq_count", 64'(seq_log.size()), 64'd130);
        if (seq_log.size() >= 129) begin
            check("seq_127", {57'd0, seq_log[126]}, 64'd127);
            check("seq_wrap0", {57'd0, seq_log[127]}, 64'd0);
            check("seq_wrap1", {57'd0, seq_log[128]}, 64'd1);
        end

        // RX overflow with rx_ready held low
        rx_ready = 1'b0;
        rs_en = 1'b1;
        for (int i = 0; i < 17; i++) begin
            rand_pkt(1'b1);
            @(negedge clk);
        end
        dout_in = '0;
        repeat (2) @(negedge clk);
        rs_en = 1'b0;
        check("ovf_resend_pulses", 64'(rs_cnt), 64'd1);
        check("ovf_drop_cnt", {48'd0, drop_cnt}, 64'd1);
        check("ovf_rx_valid", {63'd0, rx_valid}, 64'd1);
        rx_ready = 1'b1;
        repeat (20) @(negedge clk);
        rx_ready = 1'b0;
        check("rx_drained", {63'd0, rx_valid}, 64'd0);

        // stop with 5 words in flight
        em_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push_word($urandom, 5'($urandom), 4'($urandom));
            if (i == 4) stop_req = 1'b1;
            @(negedge clk);
        end
        tx_valid = 1'b0;
        stop_req = 1'b0;
        waited = 0;
        while (ap_start && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        repeat (2) @(negedge clk);
        em_en = 1'b0;
        check("stop_emitted", 64'(em_cnt), 64'd5);
        check("stop_ap_start", {63'd0, ap_start}, 64'd0);
        check("stop_idle_ready", {63'd0, tx_ready}, 64'd0);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            start_req = ($urandom_range(0, 19) == 0);
            stop_req  = ($urandom_range(0, 29) == 0);
            reset     = ($urandom_range(0, 249) == 0);
            if ($urandom_range(0, 1) == 1) push_word($urandom, 5'($urandom), 4'($urandom));
            else tx_valid = 1'b0;
            rx_ready  = ($urandom_range(0, 3) != 0);
            rand_pkt(1'b0);
            @(negedge clk);
        end
        start_req = 1'b0; stop_req = 1'b0; reset = 1'b0; tx_valid = 1'b0; dout_in = '0;
        rx_ready = 1'b0;
        @(negedge clk);

        // reset mid-operation with words and RX packets buffered
        start_req = 1'b1;
        @(negedge clk);
        start_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push_word($urandom, 5'($urandom), 4'($urandom));
            rand_pkt(1'b1);
            @(negedge clk);
        end
        tx_valid = 1'b0;
        dout_in = '0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (din[48]) vcnt++;
            @(negedge clk);
        end
        check("rst_no_emit", 64'(vcnt), 64'd0);
        check("rst_mid_rx_valid", {63'd0, rx_valid}, 64'd0);
        check("rst_mid_drop_cnt", {48'd0, drop_cnt}, 64'd0);
        check("rst_mid_ap_start", {63'd0, ap_start}, 64'd0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/leaf_bft_endpoint.md
LEAF_BFT_ENDPOINT -- requirements
Module: leaf_bft_endpoint

Interface
REQ-001 Parameters SHALL be as follows: PKT_W, 49, BFT packet width; DATA_W, 32, payload width; ADDR_W, 5, leaf address width; PORT_W, 4, port width; SEQ_W, 7, sequence width; TX_DEPTH, 16, TX FIFO entries (power of 2); RX_DEPTH, 16, RX FIFO entries (power of 2).
REQ-002 The block SHALL have one clock; reset is synchronous and active-high. Ports are listed as: name, direction, width, meaning.
REQ-003 clk, in, 1, sole clock.
REQ-004 reset, in, 1, synchronous active-high reset.
REQ-005 start_req, in, 1, pulse; starts the leaf.
REQ-006 stop_req, in, 1, pulse; stops the leaf after the TX FIFO drains.
REQ-007 tx_data, tx_addr, tx_port, in, 32/5/4, upstream payload, destination leaf and destination port.
REQ-008 tx_valid / tx_ready, in / out, 1/1, upstream valid/ready handshake.
REQ-009 din_leaf_bft2interface, out, PKT_W, packet toward the leaf.
REQ-010 dout_leaf_interface2bft, in, PKT_W, packet from the leaf.
REQ-011 resend, out, 1, retransmit request to the leaf.
REQ-012 ap_start, out, 1, leaf run enable.
REQ-013 rx_data, rx_addr, rx_port, out, 32/5/4, received payload, source address field and port field.
REQ-014 rx_valid / rx_ready, out / in, 1/1, downstream valid/ready handshake.
REQ-015 drop_cnt, out, 16, count of dropped RX packets.

Function
REQ-016 Packet format SHALL be [48] valid, [47:43] addr, [42:39] port, [38:32] seq, [31:0] data.
REQ-017 The control FSM SHALL have states IDLE, RUN and DRAIN, with these transitions:
- IDLE to RUN on start_req.
- RUN to DRAIN on stop_req.
- DRAIN to IDLE when the TX FIFO is empty and no packet is in the output register.
- start_req in DRAIN SHALL return the FSM to RUN.
- If start_req and stop_req are both asserted, stop_req SHALL win in RUN and start_req SHALL win in IDLE/DRAIN.
REQ-018 ap_start SHALL be registered, and SHALL be 1 exactly when the state is RUN or DRAIN.
REQ-019 tx_ready SHALL be !tx_full && state==RUN; a word SHALL be written when tx_valid && tx_ready.
REQ-020 In RUN or DRAIN, one TX entry per cycle SHALL be popped into the output register with valid=1 and seq=tx_seq; otherwise the output SHALL be all-zero.
REQ-021 tx_seq SHALL increment per emitted packet and wrap from 127 to 0.
REQ-022 TX latency: a word accepted at edge N into an empty FIFO SHALL appear on din_leaf_bft2interface after edge N+1.
REQ-023 An incoming packet SHALL be written to the RX FIFO when bit 48 is 1 and the FIFO is not full, or when it is full but a pop occurs in the same cycle.
REQ-024 An incoming valid packet that cannot be written SHALL be dropped, and the block SHALL, at the next edge:
- assert resend for exactly 1 cycle;
- increment drop_cnt, saturating at 0xFFFF.
REQ-025 Consecutive drops SHALL hold resend high on each following cycle.
REQ-026 rx_valid SHALL equal !rx_empty.
REQ-027 rx_* fields SHALL show the FIFO head; a pop SHALL occur on rx_valid && rx_ready.
REQ-028 RX SHALL operate in all FSM states.
REQ-029 Simultaneous push and pop SHALL keep occupancy unchanged.
REQ-030 Full and empty SHALL be derived from pointers one bit wider than log2(depth).

Reset
REQ-031 Reset SHALL set the FSM to IDLE and both FIFOs empty.
REQ-032 Reset SHALL clear tx_seq and drop_cnt to 0.
REQ-033 After reset, din_leaf_bft2interface, resend, ap_start, tx_ready and rx_valid SHALL all be 0.
REQ-034 Reset asserted mid-operation SHALL discard all buffered packets with no partial emission after the reset edge.

Structure
REQ-035 A shared package SHALL hold the packet field offsets and widths, the FSM state enum and the default parameter constants.
REQ-036 One sub-module, sync_fifo (parameterised width and depth, first-word-fall-through), SHALL be instantiated twice: once for TX and once for RX.

Verification
REQ-037 The bench SHALL cover these directed scenarios:
- Reset, then start_req -> ap_start=1 one cycle later; tx_ready=1.
- Push data 0xDEADBEEF, addr 3, port 2 -> din_leaf_bft2interface = {1,5'd3,4'd2,7'd0,32'hDEADBEEF} two edges after acceptance.
- Send 130 packets -> seq wraps 127 to 0 to 1.
- Hold rx_ready=0 and inject 17 valid packets -> 16 stored, 1 dropped, resend pulses once, drop_cnt=1.
- Issue stop_req with 5 words queued -> all 5 emitted, then ap_start=0 and state IDLE.
- Assert reset with 8 words queued -> no further valid packets emitted, rx_valid=0, drop_cnt=0.
